// File: rtl/paddle_pkg.sv
// Shared types and constants for the paddle quadrature encoder.
// Holds the FSM state enum, the Gray phase-to-{a,b} table and the
// signed position-delta type.
package paddle_pkg;

   typedef enum logic [1:0] {
      ST_SYNC = 2'd0,
      ST_IDLE = 2'd1,
      ST_STEP = 2'd2
   } state_t;

   typedef logic signed [8:0] delta_t;

   // Phase index p -> {a,b}: 0:00, 1:01, 2:11, 3:10 (two bits per entry, p=0 in the LSBs)
   localparam logic [7:0] PHASE_TABLE = 8'b10_11_01_00;

   function automatic logic [1:0] phase_ab(input logic [1:0] p);
      return PHASE_TABLE[{p, 1'b0} +: 2];
   endfunction

   function automatic logic [8:0] abs_delta(input delta_t d);
      return d[8] ? 9'(-d) : 9'(d);
   endfunction

endpackage

// File: rtl/paddle_quad_enc_quad_sync2.sv
// Two-flop synchronizer for the external encoder phases, plus a
// one-cycle pulse whenever the synchronized pair changes.
module quad_sync2 (
   input  logic       clk_sys,
   input  logic       reset,
   input  logic       ext_a,
   input  logic       ext_b,
   output logic [1:0] sync_ab,
   output logic       change
);

   logic [1:0] meta;
   logic [1:0] sync;
   logic [1:0] prev;

   // Synchronizer chain and the one-cycle-delayed copy used for edge detection
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         meta <= 2'b00;
         sync <= 2'b00;
         prev <= 2'b00;
      end else begin
         meta <= {ext_a, ext_b};
         sync <= meta;
         prev <= sync;
      end
   end

   assign sync_ab = sync;
   assign change  = (sync != prev);

endmodule

// File: rtl/paddle_quad_enc.sv
// Absolute paddle position -> rate-limited quadrature stream, with
// automatic hand-over to a physical encoder on ext_a/ext_b.
// Optional build macro PADDLE_DEADZONE_EN: a move starts from idle only
// when |target-pos| exceeds DEADZONE; once moving it runs to delta 0.
//
// state | meaning
// SYNC  | waiting for target_en; first enabled cycle loads pos from target
// IDLE  | pos matches target (or within deadzone); no steps pending
// STEP  | divider running; one phase step per terminal count until delta 0
import paddle_pkg::*;

module paddle_quad_enc #(
   parameter int STEP_DIV = 5500,
   parameter int DEADZONE = 2
) (
   input  logic       clk_sys,
   input  logic       reset,
   input  logic [7:0] target,
   input  logic       target_en,
   input  logic       ext_a,
   input  logic       ext_b,
   output logic       enc_a,
   output logic       enc_b,
   output logic       use_ext,
   output logic       busy
);

   localparam logic [15:0] DIV_LAST = 16'(STEP_DIV - 1);

   state_t      state;
   state_t      state_next;
   logic [15:0] div;
   logic [1:0]  p;
   logic [7:0]  pos;
   delta_t      delta;
   logic        tc;
   logic        start;
   logic        load;
   logic        step_inc;
   logic        step_dec;
   logic        step_q;
   logic        use_ext_q;
   logic        use_ext_next;
   logic [1:0]  enc_q;
   logic [1:0]  ext_ab;
   logic        ext_chg;

   quad_sync2 u_sync (
      .clk_sys (clk_sys),
      .reset   (reset),
      .ext_a   (ext_a),
      .ext_b   (ext_b),
      .sync_ab (ext_ab),
      .change  (ext_chg)
   );

   // Both operands are 0..255, so delta spans -255..255 and a step can never leave that range
   assign delta = delta_t'({1'b0, target}) - delta_t'({1'b0, pos});
   assign tc    = (div == DIV_LAST);

`ifdef PADDLE_DEADZONE_EN
   assign start = (abs_delta(delta) > 9'(DEADZONE));
`else
   logic unused_deadzone;
   assign unused_deadzone = (DEADZONE < 0);
   assign start = (delta != 9'sd0);
`endif

   // State register
   always_ff @(posedge clk_sys) begin
      if (reset) state <= ST_SYNC;
      else       state <= state_next;
   end

   // Next-state logic
   always_comb begin
      state_next = state;
      case (state)
         ST_SYNC: if (target_en) state_next = ST_IDLE;
         ST_IDLE: begin
            if (!target_en)  state_next = ST_SYNC;
            else if (start)  state_next = ST_STEP;
         end
         ST_STEP: begin
            if (!target_en)                      state_next = ST_SYNC;
            else if (tc && (delta == 9'sd0))     state_next = ST_IDLE;
         end
         default: state_next = ST_SYNC;
      endcase
   end

   // FSM outputs: position load, step requests and busy flag
   always_comb begin
      load     = 1'b0;
      step_inc = 1'b0;
      step_dec = 1'b0;
      busy     = 1'b0;
      case (state)
         ST_SYNC: load = target_en;
         ST_STEP: begin
            busy = 1'b1;
            if (target_en && tc) begin
               step_inc = !delta[8] && (delta != 9'sd0);
               step_dec = delta[8];
            end
         end
         default: ;
      endcase
   end

   // Divider, phase index and told-position datapath
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         div    <= 16'd0;
         p      <= 2'd0;
         pos    <= 8'd0;
         step_q <= 1'b0;
      end else begin
         step_q <= step_inc | step_dec;
         if (load) begin
            pos <= target;
         end else if (step_inc) begin
            pos <= pos + 8'd1;
            p   <= p + 2'd1;
         end else if (step_dec) begin
            pos <= pos - 8'd1;
            p   <= p - 2'd1;
         end
         if ((state != ST_STEP) || tc) div <= 16'd0;
         else                          div <= div + 16'd1;
      end
   end

   // An external edge wins over a synthesized step landing in the same cycle
   assign use_ext_next = ext_chg ? 1'b1 : (step_q ? 1'b0 : use_ext_q);

   // Registered source select and output mux
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         use_ext_q <= 1'b0;
         enc_q     <= 2'b00;
      end else begin
         use_ext_q <= use_ext_next;
         enc_q     <= use_ext_next ? ext_ab : phase_ab(p);
      end
   end

   assign enc_a   = enc_q[1];
   assign enc_b   = enc_q[0];
   assign use_ext = use_ext_q;

endmodule

// File: tb/tb_paddle_quad_enc.sv
// Self-checking bench for paddle_quad_enc (STEP_DIV shortened to 4).
module tb_paddle_quad_enc;

   localparam int SD = 4;
   localparam int DZ = 2;

   logic       clk_sys = 1'b0;
   logic       reset;
   logic [7:0] target;
   logic       target_en;
   logic       ext_a;
   logic       ext_b;
   logic       enc_a;
   logic       enc_b;
   logic       use_ext;
   logic       busy;

   paddle_quad_enc #(.STEP_DIV(SD), .DEADZONE(DZ)) dut (
      .clk_sys   (clk_sys),
      .reset     (reset),
      .target    (target),
      .target_en (target_en),
      .ext_a     (ext_a),
      .ext_b     (ext_b),
      .enc_a     (enc_a),
      .enc_b     (enc_b),
      .use_ext   (use_ext),
      .busy      (busy)
   );

   always #5 clk_sys = ~clk_sys;

   typedef struct {
      logic [7:0] tgt;
      int         steps;
      logic [1:0] ab;
   } vec_t;

   int         n_pass  = 0;
   int         n_total = 0;
   int         cyc     = 0;
   int         trans_q[$];
   int         dbl_cnt = 0;
   logic [1:0] prev_ab;
   logic       prev_ue;
   logic       prev_rst = 1'b1;
   logic [1:0] gray_tb [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
   int         m_p;
   int         m_pos;
   vec_t       vecs [5];

   always @(posedge clk_sys) cyc <= cyc + 1;

   // Records every synthesized phase transition (outside reset, synth source selected)
   always @(negedge clk_sys) begin
      if (!reset && !prev_rst && !use_ext && !prev_ue && ({enc_a, enc_b} != prev_ab)) begin
         trans_q.push_back(cyc);
         if (({enc_a, enc_b} ^ prev_ab) == 2'b11) dbl_cnt <= dbl_cnt + 1;
      end
      prev_ab  <= {enc_a, enc_b};
      prev_ue  <= use_ext;
      prev_rst <= reset;
   end

   task automatic chk(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   task automatic ticks(input int n);
      repeat (n) tick();
   endtask

   task automatic do_reset(input logic [7:0] t);
      ext_a     = 1'b0;
      ext_b     = 1'b0;
      reset     = 1'b1;
      target_en = 1'b0;
      target    = t;
      ticks(2);
      reset     = 1'b0;
      target_en = 1'b1;
      ticks(2);
      m_p   = 0;
      m_pos = int'(t);
   endtask

   task automatic wait_idle(input string name, input int budget);
      int n;
      n = 0;
      ticks(2);
      while (busy && n < budget) begin
         tick();
         n++;
      end
      chk({name, "_idle"}, int'(busy), 0);
   endtask

   task automatic wait_trans(input string name, input int base, input int cnt);
      int n;
      n = 0;
      while ((trans_q.size() - base) < cnt && n < 200) begin
         tick();
         n++;
      end
      chk({name, "_reached"}, int'((trans_q.size() - base) >= cnt), 1);
   endtask

   task automatic check_run(input string name, input int base, input int dbase,
                            input int exp_n, input logic [1:0] exp_ab);
      int ok;
      ok = 1;
      for (int i = base + 1; i < trans_q.size(); i++)
         if (trans_q[i] - trans_q[i-1] != SD) ok = 0;
      chk({name, "_steps"}, trans_q.size() - base, exp_n);
      chk({name, "_gap"}, ok, 1);
      chk({name, "_onebit"}, dbl_cnt - dbase, 0);
      chk({name, "_ab"}, int'({enc_a, enc_b}), int'(exp_ab));
   endtask

   // Model: phase tracks told position (p - pos constant between resyncs); pos clamps to target
   task automatic model_move(input string name, input int t);
      int d, ad, base, dbase;
      d  = t - m_pos;
      ad = (d < 0) ? -d : d;
`ifdef PADDLE_DEADZONE_EN
      if (ad <= DZ) ad = 0;
`endif
      if (ad != 0) begin
         m_pos = t;
         m_p   = (((m_p + d) % 4) + 4) % 4;
      end
      base   = trans_q.size();
      dbase  = dbl_cnt;
      target = 8'(t);
      wait_idle(name, (ad + 2) * SD + 20);
      check_run(name, base, dbase, ad, gray_tb[m_p]);
      chk({name, "_use_ext"}, int'(use_ext), 0);
   endtask

   initial begin
      int base, dbase, t, r;
`ifdef PADDLE_DEADZONE_EN
      vecs[0] = '{8'd102, 0, 2'b00};
      vecs[1] = '{8'd103, 3, 2'b10};
      vecs[2] = '{8'd101, 0, 2'b10};
      vecs[3] = '{8'd100, 3, 2'b00};
      vecs[4] = '{8'd98,  0, 2'b00};
`else
      vecs[0] = '{8'd103, 3, 2'b10};
      vecs[1] = '{8'd101, 2, 2'b01};
      vecs[2] = '{8'd101, 0, 2'b01};
      vecs[3] = '{8'd105, 4, 2'b01};
      vecs[4] = '{8'd104, 1, 2'b00};
`endif

      // Reset state
      ext_a = 1'b0; ext_b = 1'b0; target = 8'd0; target_en = 1'b0; reset = 1'b1;
      ticks(3);
      chk("rst_enc", int'({enc_a, enc_b}), 0);
      chk("rst_use_ext", int'(use_ext), 0);
      chk("rst_busy", int'(busy), 0);

      // Sync without steps
      do_reset(8'd100);
      base = trans_q.size();
      ticks(20);
      chk("sync_steps", trans_q.size() - base, 0);
      chk("sync_busy", int'(busy), 0);
      chk("sync_enc", int'({enc_a, enc_b}), 0);

      // Table-driven moves from pos 100, phase 0
      for (int i = 0; i < 5; i++) begin
         base   = trans_q.size();
         dbase  = dbl_cnt;
         target = vecs[i].tgt;
         wait_idle($sformatf("vec%0d", i), 100);
         check_run($sformatf("vec%0d", i), base, dbase, vecs[i].steps, vecs[i].ab);
      end

      // Mid-run reversal: 2 up, then 3 down to 99 -> phase 3
      do_reset(8'd100);
      base = trans_q.size(); dbase = dbl_cnt;
      target = 8'd110;
      wait_trans("rev_up", base, 2);
      target = 8'd99;
      wait_idle("rev", 200);
      check_run("rev", base, dbase, 5, 2'b10);

      // Clamp run 250->255 interrupted by reset during step 3
      do_reset(8'd250);
      base = trans_q.size();
      target = 8'd255;
      wait_trans("clamp_up", base, 2);
      tick();
      reset = 1'b1; target_en = 1'b0;
      tick();
      chk("midrst_enc", int'({enc_a, enc_b}), 0);
      chk("midrst_use_ext", int'(use_ext), 0);
      chk("midrst_busy", int'(busy), 0);
      tick();
      reset = 1'b0;
      ticks(3);
      base = trans_q.size();
      target_en = 1'b1;
      ticks(40);
      chk("resync_steps", trans_q.size() - base, 0);
      chk("resync_busy", int'(busy), 0);
      chk("resync_enc", int'({enc_a, enc_b}), 0);

      // Auto-select: external edge takes over 3 cycles later
      do_reset(8'd100);
      ext_a = 1'b1;
      tick();
      chk("ext_lat1", int'(use_ext), 0);
      tick();
      chk("ext_lat2", int'(use_ext), 0);
      chk("ext_lat2_a", int'(enc_a), 0);
      tick();
      chk("ext_sel", int'(use_ext), 1);
      chk("ext_follow", int'({enc_a, enc_b}), 2);
      ext_a = 1'b0;
      ticks(3);
      chk("ext_follow0", int'({enc_a, enc_b}), 0);
      target = 8'd101;
      wait_idle("ext_step", 50);
      chk("step_clears", int'(use_ext), 0);
      chk("step_ab", int'({enc_a, enc_b}), 1);
      // Step lands in the same cycle as an external change
      target = 8'd102;
      ticks(3);
      ext_b = 1'b1;
      ticks(2);
      chk("simul_pre", int'(use_ext), 0);
      tick();
      chk("simul_ext_wins", int'(use_ext), 1);
      chk("simul_enc", int'({enc_a, enc_b}), 1);
      wait_idle("simul", 50);
      chk("simul_hold", int'(use_ext), 1);

      // Randomized moves against the model
      do_reset(8'(int'($urandom_range(0, 255))));
      for (int k = 0; k < 30; k++) begin
         r = int'($urandom_range(0, 9));
         if (r == 0) begin
            target_en = 1'b0;
            ticks(2);
            t = int'($urandom_range(0, 255));
            target = 8'(t);
            base = trans_q.size();
            target_en = 1'b1;
            ticks(3);
            m_pos = t;
            chk($sformatf("rnd%0d_resync", k), trans_q.size() - base, 0);
         end else begin
            if (r == 1) t = ($urandom_range(0, 1) != 0) ? 255 : 0;
            else begin
               t = m_pos + int'($urandom_range(0, 12)) - 6;
               if (t < 0) t = 0;
               if (t > 255) t = 255;
            end
            model_move($sformatf("rnd%0d", k), t);
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
